// File: rtl/game_state_updater.sv
// game_state_updater: sequential game-logic core of color_crasher.
// Moves and recolours the player block, fires and advances up to NUM_BULLETS
// bullets, resolves colour-matched hits against the ddaver grid and respawns
// ddavers from an 8-bit LFSR.
// Optional build macro GSU_AUTOFIRE_EN: while z is held, every bullet step
// also attempts a fire (at most one fire per cycle).
module game_state_updater #(
    parameter int         NUM_ROWS    = 5,
    parameter int         NUM_COLS    = 6,
    parameter int         NUM_BULLETS = 3,
    parameter int         DDAVER_X0   = 10,
    parameter logic [7:0] STICK_HI    = 8'd192,
    parameter logic [7:0] STICK_LO    = 8'd64,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        blockieee_tick,
    input  logic        ddaver_tick,
    input  logic        bullet_tick,
    input  logic [7:0]  stick_y,
    input  logic        z,
    input  logic        c,
    output logic [3:0]  blockieee,
    output logic [11:0] player_color,
    output logic [11:0] ddavers [0:NUM_ROWS-1][0:NUM_COLS-1],
    output logic [11:0] bulletBillColor [0:NUM_BULLETS-1],
    output logic [3:0]  bulletBillXLoc [0:NUM_BULLETS-1],
    output logic [3:0]  bulletBillYLoc [0:NUM_BULLETS-1],
    output logic [7:0]  score
);

    // Bit positions of the edge-detected inputs.
    localparam int EVT_MOVE = 0;
    localparam int EVT_DD   = 1;
    localparam int EVT_BUL  = 2;
    localparam int EVT_Z    = 3;
    localparam int EVT_C    = 4;

    function automatic logic [11:0] pal(input logic [1:0] i);
        case (i)
            2'd0:    pal = 12'hF00;
            2'd1:    pal = 12'h0F0;
            2'd2:    pal = 12'h00F;
            default: pal = 12'hFF0;
        endcase
    endfunction

    logic [4:0]  raw_in;
    logic [4:0]  in_reg;
    logic [4:0]  in_q_reg;
    logic [4:0]  evt;
    logic        fire_evt;

    logic [3:0]  row_reg, row_next;
    logic [1:0]  idx_reg, idx_next;
    logic [11:0] color_reg;
    logic [7:0]  score_reg, score_next;
    logic [7:0]  lfsr_reg, lfsr_next;

    logic [11:0] grid_reg  [0:NUM_ROWS-1][0:NUM_COLS-1];
    logic [11:0] grid_next [0:NUM_ROWS-1][0:NUM_COLS-1];
    logic        cleared   [0:NUM_ROWS-1][0:NUM_COLS-1];

    logic [11:0] bc_reg  [0:NUM_BULLETS-1];
    logic [11:0] bc_next [0:NUM_BULLETS-1];
    logic [3:0]  bx_reg  [0:NUM_BULLETS-1];
    logic [3:0]  bx_next [0:NUM_BULLETS-1];
    logic [3:0]  by_reg  [0:NUM_BULLETS-1];
    logic [3:0]  by_next [0:NUM_BULLETS-1];

    logic [3:0]  nx;
    logic [2:0]  ri;
    logic [2:0]  ki;
    logic        found;

    // Inputs are registered once; events are the registered level rising
    // against its one-cycle-older copy, giving one cycle of latency.
    assign raw_in = {c, z, bullet_tick, ddaver_tick, blockieee_tick};
    assign evt    = in_reg & ~in_q_reg;

`ifdef GSU_AUTOFIRE_EN
    assign fire_evt = evt[EVT_Z] | (evt[EVT_BUL] & in_reg[EVT_Z]);
`else
    assign fire_evt = evt[EVT_Z];
`endif

    // Next-state: move, colour, bullet step (in slot order), fire, respawn.
    always_comb begin
        row_next   = row_reg;
        idx_next   = idx_reg;
        score_next = score_reg;
        grid_next  = grid_reg;
        cleared    = '{default: 1'b0};
        bc_next    = bc_reg;
        bx_next    = bx_reg;
        by_next    = by_reg;
        nx         = 4'd0;
        ri         = 3'd0;
        ki         = 3'd0;
        found      = 1'b0;
        lfsr_next  = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};

        if (evt[EVT_MOVE]) begin
            if (stick_y > STICK_HI && row_reg != 4'd0) begin
                row_next = row_reg - 4'd1;
            end else if (stick_y < STICK_LO && row_reg < 4'(NUM_ROWS - 1)) begin
                row_next = row_reg + 4'd1;
            end
        end

        if (evt[EVT_C]) begin
            idx_next = idx_reg + 2'd1;
        end

        // Slots run in index order so later slots see earlier clears.
        if (evt[EVT_BUL]) begin
            for (int i = 0; i < NUM_BULLETS; i++) begin
                if (bc_next[i] != 12'h000) begin
                    if (bx_next[i] == 4'd15) begin
                        bc_next[i] = 12'h000;
                        bx_next[i] = 4'd0;
                        by_next[i] = 4'd0;
                    end else begin
                        nx = bx_next[i] + 4'd1;
                        ri = by_next[i][2:0];
                        ki = 3'(nx - 4'(DDAVER_X0));
                        if (int'(nx) >= DDAVER_X0 && int'(nx) <= DDAVER_X0 + NUM_COLS - 1 &&
                            int'(by_next[i]) < NUM_ROWS && grid_next[ri][ki] != 12'h000) begin
                            if (grid_next[ri][ki] == bc_next[i]) begin
                                grid_next[ri][ki] = 12'h000;
                                cleared[ri][ki]   = 1'b1;
                                if (score_next != 8'hFF) begin
                                    score_next = score_next + 8'd1;
                                end
                            end
                            bc_next[i] = 12'h000;
                            bx_next[i] = 4'd0;
                            by_next[i] = 4'd0;
                        end else begin
                            bx_next[i] = nx;
                        end
                    end
                end
            end
        end

        // New bullet uses the pre-update row and colour and may reuse a
        // slot freed by this cycle's step.
        if (fire_evt) begin
            for (int i = 0; i < NUM_BULLETS; i++) begin
                if (!found && bc_next[i] == 12'h000) begin
                    bc_next[i] = color_reg;
                    bx_next[i] = 4'd0;
                    by_next[i] = row_reg;
                    found      = 1'b1;
                end
            end
        end

        // Respawn never refills a cell that a bullet cleared this cycle.
        if (evt[EVT_DD]) begin
            ri = lfsr_reg[2:0];
            ki = lfsr_reg[5:3];
            if (int'(ri) < NUM_ROWS && int'(ki) < NUM_COLS) begin
                if (grid_next[ri][ki] == 12'h000 && !cleared[ri][ki]) begin
                    grid_next[ri][ki] = pal(lfsr_reg[7:6]);
                end
            end
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_reg    <= '0;
            in_q_reg  <= '0;
            row_reg   <= 4'd2;
            idx_reg   <= 2'd0;
            color_reg <= 12'hF00;
            score_reg <= 8'd0;
            lfsr_reg  <= LFSR_SEED;
            for (int r = 0; r < NUM_ROWS; r++) begin
                for (int k = 0; k < NUM_COLS; k++) begin
                    grid_reg[r][k] <= pal(2'(r + k));
                end
            end
            for (int i = 0; i < NUM_BULLETS; i++) begin
                bc_reg[i] <= 12'h000;
                bx_reg[i] <= 4'd0;
                by_reg[i] <= 4'd0;
            end
        end else begin
            in_reg    <= raw_in;
            in_q_reg  <= in_reg;
            row_reg   <= row_next;
            idx_reg   <= idx_next;
            color_reg <= pal(idx_next);
            score_reg <= score_next;
            lfsr_reg  <= lfsr_next;
            grid_reg  <= grid_next;
            bc_reg    <= bc_next;
            bx_reg    <= bx_next;
            by_reg    <= by_next;
        end
    end

    assign blockieee    = row_reg;
    assign player_color = color_reg;
    assign score        = score_reg;

    genvar gi, gk;
    generate
        for (gi = 0; gi < NUM_BULLETS; gi++) begin : g_bul
            assign bulletBillColor[gi] = bc_reg[gi];
            assign bulletBillXLoc[gi]  = bx_reg[gi];
            assign bulletBillYLoc[gi]  = by_reg[gi];
        end
        for (gi = 0; gi < NUM_ROWS; gi++) begin : g_row
            for (gk = 0; gk < NUM_COLS; gk++) begin : g_col
                assign ddavers[gi][gk] = grid_reg[gi][gk];
            end
        end
    endgenerate

endmodule

// File: tb/tb_game_state_updater.sv
// Self-checking bench for game_state_updater: a behavioural reference model
// pushes expected snapshots onto a queue when stimulus is driven; they are
// popped and compared once the DUT has produced its registered result.
module tb_game_state_updater;

    logic        clk;
    logic        rst;
    logic        blockieee_tick;
    logic        ddaver_tick;
    logic        bullet_tick;
    logic [7:0]  stick_y;
    logic        z;
    logic        c;
    logic [3:0]  blockieee;
    logic [11:0] player_color;
    logic [11:0] ddavers [0:4][0:5];
    logic [11:0] bulletBillColor [0:2];
    logic [3:0]  bulletBillXLoc [0:2];
    logic [3:0]  bulletBillYLoc [0:2];
    logic [7:0]  score;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    logic [3:0]  m_row;
    logic [1:0]  m_idx;
    logic [7:0]  m_score;
    logic [7:0]  m_lfsr;
    logic [11:0] m_grid [0:4][0:5];
    logic [11:0] m_bc [0:2];
    logic [3:0]  m_bx [0:2];
    logic [3:0]  m_by [0:2];

    typedef struct {
        logic [3:0]   row;
        logic [11:0]  color;
        logic [7:0]   score;
        logic [359:0] grid;
        logic [59:0]  bul;
    } snap_t;

    snap_t sb_q[$];

    game_state_updater dut (
        .clk             (clk),
        .rst             (rst),
        .blockieee_tick  (blockieee_tick),
        .ddaver_tick     (ddaver_tick),
        .bullet_tick     (bullet_tick),
        .stick_y         (stick_y),
        .z               (z),
        .c               (c),
        .blockieee       (blockieee),
        .player_color    (player_color),
        .ddavers         (ddavers),
        .bulletBillColor (bulletBillColor),
        .bulletBillXLoc  (bulletBillXLoc),
        .bulletBillYLoc  (bulletBillYLoc),
        .score           (score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] pal(input logic [1:0] i);
        case (i)
            2'd0:    return 12'hF00;
            2'd1:    return 12'h0F0;
            2'd2:    return 12'h00F;
            default: return 12'hFF0;
        endcase
    endfunction

    function automatic logic [7:0] lfsr_shift(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Reference LFSR runs free alongside the DUT from reset.
    always @(posedge clk or negedge rst) begin
        if (!rst) m_lfsr <= 8'hA5;
        else      m_lfsr <= lfsr_shift(m_lfsr);
    end

    task automatic chk(input string tag, input logic [359:0] got, input logic [359:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        s.row   = m_row;
        s.color = pal(m_idx);
        s.score = m_score;
        s.grid  = '0;
        s.bul   = '0;
        for (int r = 0; r < 5; r++)
            for (int k = 0; k < 6; k++)
                s.grid[(r*6+k)*12 +: 12] = m_grid[r][k];
        for (int i = 0; i < 3; i++)
            s.bul[i*20 +: 20] = {m_bc[i], m_bx[i], m_by[i]};
        return s;
    endfunction

    function automatic snap_t dut_snap();
        snap_t s;
        s.row   = blockieee;
        s.color = player_color;
        s.score = score;
        s.grid  = '0;
        s.bul   = '0;
        for (int r = 0; r < 5; r++)
            for (int k = 0; k < 6; k++)
                s.grid[(r*6+k)*12 +: 12] = ddavers[r][k];
        for (int i = 0; i < 3; i++)
            s.bul[i*20 +: 20] = {bulletBillColor[i], bulletBillXLoc[i], bulletBillYLoc[i]};
        return s;
    endfunction

    task automatic model_reset();
        m_row   = 4'd2;
        m_idx   = 2'd0;
        m_score = 8'd0;
        for (int r = 0; r < 5; r++)
            for (int k = 0; k < 6; k++)
                m_grid[r][k] = pal(2'(r + k));
        for (int i = 0; i < 3; i++) begin
            m_bc[i] = 12'h000;
            m_bx[i] = 4'd0;
            m_by[i] = 4'd0;
        end
        sb_q.push_back(model_snap());
    endtask

    task automatic model_step(input bit mv, input bit cc, input bit zz, input bit bt,
                              input bit dd, input logic [7:0] lf);
        logic [3:0] old_row;
        logic [1:0] old_idx;
        logic [4:0] nx;
        logic [2:0] r3;
        logic [2:0] k3;
        bit         clr [0:4][0:5];
        bit         placed;
        old_row = m_row;
        old_idx = m_idx;
        placed  = 1'b0;
        for (int r = 0; r < 5; r++)
            for (int k = 0; k < 6; k++)
                clr[r][k] = 1'b0;
        if (mv) begin
            if (stick_y > 8'd192 && m_row > 4'd0)      m_row = m_row - 4'd1;
            else if (stick_y < 8'd64 && m_row < 4'd4)  m_row = m_row + 4'd1;
        end
        if (cc) m_idx = m_idx + 2'd1;
        if (bt) begin
            for (int i = 0; i < 3; i++) begin
                if (m_bc[i] != 12'h000) begin
                    nx = {1'b0, m_bx[i]} + 5'd1;
                    if (m_bx[i] == 4'd15) begin
                        m_bc[i] = 12'h000; m_bx[i] = 4'd0; m_by[i] = 4'd0;
                    end else if (nx >= 5'd10 && nx <= 5'd15 && m_by[i] < 4'd5 &&
                                 m_grid[m_by[i][2:0]][3'(nx - 5'd10)] != 12'h000) begin
                        r3 = m_by[i][2:0];
                        k3 = 3'(nx - 5'd10);
                        if (m_grid[r3][k3] == m_bc[i]) begin
                            m_grid[r3][k3] = 12'h000;
                            clr[r3][k3]    = 1'b1;
                            if (m_score != 8'hFF) m_score = m_score + 8'd1;
                        end
                        m_bc[i] = 12'h000; m_bx[i] = 4'd0; m_by[i] = 4'd0;
                    end else begin
                        m_bx[i] = nx[3:0];
                    end
                end
            end
        end
        if (zz) begin
            for (int i = 0; i < 3; i++) begin
                if (!placed && m_bc[i] == 12'h000) begin
                    m_bc[i] = pal(old_idx); m_bx[i] = 4'd0; m_by[i] = old_row;
                    placed = 1'b1;
                end
            end
        end
        if (dd) begin
            r3 = lf[2:0];
            k3 = lf[5:3];
            if (r3 < 3'd5 && k3 < 3'd6 && m_grid[r3][k3] == 12'h000 && !clr[r3][k3])
                m_grid[r3][k3] = pal(lf[7:6]);
        end
        sb_q.push_back(model_snap());
    endtask

    task automatic compare_dut();
        snap_t e;
        snap_t g;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 360'd0, 360'd1);
        end else begin
            e = sb_q.pop_front();
            g = dut_snap();
            chk("row",     {356'd0, g.row},   {356'd0, e.row});
            chk("color",   {348'd0, g.color}, {348'd0, e.color});
            chk("score",   {352'd0, g.score}, {352'd0, e.score});
            chk("grid",    g.grid,            e.grid);
            chk("bullets", {300'd0, g.bul},   {300'd0, e.bul});
        end
    endtask

    // Called at a negedge; pulses the chosen inputs for one cycle and checks
    // the result at the negedge after the DUT's one-cycle event latency.
    task automatic do_events(input bit mv, input bit cc, input bit zz, input bit bt, input bit dd);
        logic [7:0] lf;
        lf = lfsr_shift(m_lfsr);
        blockieee_tick = mv; c = cc; z = zz; bullet_tick = bt; ddaver_tick = dd;
        @(negedge clk);
        blockieee_tick = 1'b0; c = 1'b0; z = 1'b0; bullet_tick = 1'b0; ddaver_tick = 1'b0;
        model_step(mv, cc, zz, bt, dd, lf);
        @(negedge clk);
        txn++;
        $display("txn %0d ev=%b%b%b%b%b lfsr=%02h row=%0d score=%0d",
                 txn, mv, cc, zz, bt, dd, lf, blockieee, score);
        compare_dut();
    endtask

    task automatic fly_slot0();
        for (int t = 0; t < 20 && m_bc[0] != 12'h000; t++)
            do_events(0, 0, 0, 1, 0);
        chk("slot0_done", {348'd0, m_bc[0]}, 360'd0);
    endtask

    // mode 0: in-range empty cell in row 0; 1: row out of range; 2: column out of range
    task automatic respawn_when(input int mode);
        logic [7:0] lf;
        bit         hit;
        bit         want;
        hit = 1'b0;
        for (int n = 0; n < 600 && !hit; n++) begin
            lf = lfsr_shift(m_lfsr);
            case (mode)
                0:       want = (lf[2:0] == 3'd0) && (lf[5:3] < 3'd6) && (m_grid[0][lf[5:3]] == 12'h000);
                1:       want = (lf[2:0] >= 3'd5);
                default: want = (lf[2:0] < 3'd5) && (lf[5:3] >= 3'd6);
            endcase
            if (want) begin
                do_events(0, 0, 0, 0, 1);
                hit = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        chk("respawn_search", {359'd0, hit}, 360'd1);
    endtask

    initial begin
        rst = 1'b0;
        blockieee_tick = 1'b0; ddaver_tick = 1'b0; bullet_tick = 1'b0;
        z = 1'b0; c = 1'b0; stick_y = 8'd128;
        repeat (3) @(negedge clk);
        model_reset();
        compare_dut();
        rst = 1'b1;
        @(negedge clk);

        // Player movement with saturation at both ends, then back to row 0.
        stick_y = 8'd255; repeat (3) do_events(1, 0, 0, 0, 0);
        stick_y = 8'd0;   repeat (6) do_events(1, 0, 0, 0, 0);
        stick_y = 8'd255; repeat (4) do_events(1, 0, 0, 0, 0);
        stick_y = 8'd128;

        // Green bullet into red cell: bullet removed, cell kept, no score.
        do_events(0, 1, 0, 0, 0);
        do_events(0, 0, 1, 0, 0);
        fly_slot0();

        // Clear row 0 one cell at a time with matching colours.
        for (int j = 0; j < 6; j++) begin
            for (int t = 0; t < 4 && m_idx != 2'(j % 4); t++)
                do_events(0, 1, 0, 0, 0);
            do_events(0, 0, 1, 0, 0);
            fly_slot0();
        end

        // Fill all slots (4th fire dropped), run to X=15, then step+fire together.
        repeat (4) do_events(0, 0, 1, 0, 0);
        repeat (15) do_events(0, 0, 0, 1, 0);
        do_events(0, 0, 1, 1, 0);
        do_events(0, 0, 0, 1, 0);

        // Everything in one cycle.
        stick_y = 8'd0;
        do_events(1, 1, 1, 1, 1);
        stick_y = 8'd128;

        // Respawn into an empty cell, then out-of-range row and column.
        respawn_when(0);
        respawn_when(1);
        respawn_when(2);

        // Asynchronous reset mid-flight.
        bullet_tick = 1'b1; z = 1'b1;
        #2 rst = 1'b0;
        #1;
        model_reset();
        compare_dut();
        bullet_tick = 1'b0; z = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        stick_y = 8'd255;
        do_events(1, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
